// File: rtl/cpu_run_controller_if.sv
// Host handshake and CPU pin bundle for cpu_run_controller.
// slave = controller side, master = host/CPU side.
interface cpu_run_controller_if #(
    parameter int DATA_W = 16,
    parameter int CYC_W  = 24
);
    logic              start;
    logic [DATA_W-1:0] arg;
    logic              abort;
    logic              ready;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [DATA_W-1:0] result;
    logic [CYC_W-1:0]  cycles;
    logic              cpu_reset;
    logic [DATA_W-1:0] cpu_input;
    logic [DATA_W-1:0] cpu_output;

    modport master (
        output start, arg, abort, cpu_output,
        input  ready, busy, done, timed_out, result, cycles, cpu_reset, cpu_input
    );

    modport slave (
        input  start, arg, abort, cpu_output,
        output ready, busy, done, timed_out, result, cycles, cpu_reset, cpu_input
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Sequences one CPU program run: load argument, pulse CPU reset, wait for a
// stable nonzero output, then report result and run length.
module cpu_run_controller #(
    parameter int               DATA_W         = 16,
    parameter int               RESET_CYCLES   = 2,
    parameter int               STABLE_CYCLES  = 1,
    parameter int               CYC_W          = 24,
    parameter logic [CYC_W-1:0] TIMEOUT_CYCLES = CYC_W'(24'hFFFFFF)
) (
    input logic                 CLK,
    input logic                 reset,
    cpu_run_controller_if.slave bus
);
    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int ST_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RST_CPU, S_RUN, S_FINISH} state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_timed_out;
    logic [DATA_W-1:0] r_result;
    logic [CYC_W-1:0]  r_cycles;
    logic              r_cpu_reset;
    logic [DATA_W-1:0] r_cpu_input;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [ST_W-1:0]   r_stab;
    logic [DATA_W-1:0] r_prev;

    logic [ST_W-1:0]   w_stab_nxt;
    logic [CYC_W-1:0]  w_cyc_nxt;

    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.timed_out = r_timed_out;
    assign bus.result    = r_result;
    assign bus.cycles    = r_cycles;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.cpu_input = r_cpu_input;

    assign w_cyc_nxt = r_cycles + CYC_W'(1);

    // r_prev is only meaningful while r_stab is nonzero, so no clear is needed at run start.
    always_comb begin
        w_stab_nxt = ST_W'(1);
        if (bus.cpu_output == '0)
            w_stab_nxt = '0;
        else if (r_stab != '0 && bus.cpu_output == r_prev)
            w_stab_nxt = r_stab + ST_W'(1);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_result    <= '0;
            r_cycles    <= '0;
            r_cpu_reset <= 1'b1;
            r_cpu_input <= '0;
            r_rst_cnt   <= '0;
            r_stab      <= '0;
            r_prev      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state     <= S_RST_CPU;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cpu_input <= bus.arg;
                        r_result    <= '0;
                        r_cycles    <= '0;
                        r_rst_cnt   <= '0;
                        r_stab      <= '0;
                    end
                end
                S_RST_CPU: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cpu_reset <= 1'b1;
                    end else begin
                        r_cycles <= w_cyc_nxt;
                        r_prev   <= bus.cpu_output;
                        r_stab   <= w_stab_nxt;
                        // Completion is tested first so it wins a tie with the timeout.
                        if (w_stab_nxt == ST_W'(STABLE_CYCLES)) begin
                            r_state     <= S_FINISH;
                            r_result    <= bus.cpu_output;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cpu_reset <= 1'b1;
                        end else if (w_cyc_nxt == TIMEOUT_CYCLES) begin
                            r_state     <= S_FINISH;
                            r_result    <= '0;
                            r_done      <= 1'b1;
                            r_timed_out <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: two instances (STABLE_CYCLES 1 and 3, timeout 50)
// driven by one stimulus stream and checked against a window-based run model.
module tb_cpu_run_controller;
    localparam int DW  = 16;
    localparam int CW  = 24;
    localparam int RC  = 2;
    localparam int TMO = 50;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [DW-1:0] arg;
    logic [DW-1:0] cpu_out;

    int checks = 0;
    int errors = 0;
    int stab_of [2] = '{1, 3};
    logic [DW-1:0] seq [1:TMO];
    logic [DW-1:0] last_arg;

    always #5 CLK = ~CLK;

    cpu_run_controller_if #(.DATA_W(DW), .CYC_W(CW)) bus1 ();
    cpu_run_controller_if #(.DATA_W(DW), .CYC_W(CW)) bus3 ();

    assign bus1.start = start;  assign bus1.arg = arg;  assign bus1.abort = abort;  assign bus1.cpu_output = cpu_out;
    assign bus3.start = start;  assign bus3.arg = arg;  assign bus3.abort = abort;  assign bus3.cpu_output = cpu_out;

    cpu_run_controller #(.DATA_W(DW), .RESET_CYCLES(RC), .STABLE_CYCLES(1), .CYC_W(CW),
                         .TIMEOUT_CYCLES(CW'(TMO))) dut1 (.CLK(CLK), .reset(reset), .bus(bus1));
    cpu_run_controller #(.DATA_W(DW), .RESET_CYCLES(RC), .STABLE_CYCLES(3), .CYC_W(CW),
                         .TIMEOUT_CYCLES(CW'(TMO))) dut3 (.CLK(CLK), .reset(reset), .bus(bus3));

    // Flags packed as {ready, busy, done, timed_out, cpu_reset}.
    logic [4:0]    o_flg [2];
    logic [DW-1:0] o_res [2];
    logic [DW-1:0] o_cin [2];
    logic [CW-1:0] o_cyc [2];
    assign o_flg[0] = {bus1.ready, bus1.busy, bus1.done, bus1.timed_out, bus1.cpu_reset};
    assign o_flg[1] = {bus3.ready, bus3.busy, bus3.done, bus3.timed_out, bus3.cpu_reset};
    assign o_res[0] = bus1.result;    assign o_res[1] = bus3.result;
    assign o_cin[0] = bus1.cpu_input; assign o_cin[1] = bus3.cpu_input;
    assign o_cyc[0] = bus1.cycles;    assign o_cyc[1] = bus3.cycles;

    // A run ends at the first RUN sample k whose last s samples are one identical
    // nonzero value; failing that, it is abandoned at sample TMO with result 0.
    function automatic void ref_run(input int s, output int k_end, output logic [DW-1:0] res, output bit to);
        bit ok;
        k_end = TMO; res = '0; to = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            ok = (k >= s);
            if (ok)
                for (int j = k - s + 1; j <= k; j++)
                    if (seq[j] == '0 || seq[j] != seq[k]) ok = 1'b0;
            if (ok) begin
                k_end = k; res = seq[k]; to = 1'b0;
                return;
            end
        end
    endfunction

    // t counts cycles after the accepting edge; RUN sample k happens in cycle t=k+1.
    task automatic do_run(input string name, input logic [DW-1:0] a, input int abort_t, input bit noise);
        int            kk [2];
        logic [DW-1:0] rr [2];
        bit            tt [2];
        int            kmin, kmax, last, waited;
        logic [4:0]    ef;
        logic [DW-1:0] er;
        logic [CW-1:0] ec;
        waited = 0;
        while (!(o_flg[0][4] && o_flg[1][4]) && waited < 20) begin
            @(posedge CLK); #1; waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL %s ready_timeout got flags %b/%b want ready=1", name, o_flg[0], o_flg[1]);
        end
        for (int d = 0; d < 2; d++) ref_run(stab_of[d], kk[d], rr[d], tt[d]);
        kmin = (kk[0] < kk[1]) ? kk[0] : kk[1];
        kmax = (kk[0] > kk[1]) ? kk[0] : kk[1];
        last = (abort_t >= 0) ? abort_t + 3 : kmax + 3;
        last_arg = a;
        start = 1'b1; arg = a;
        for (int t = 0; t <= last; t++) begin
            @(posedge CLK); #1;
            for (int d = 0; d < 2; d++) begin
                if (abort_t >= 0 && t > abort_t) begin
                    ef = 5'b10001; er = '0; ec = (abort_t >= 2) ? CW'(abort_t - 2) : '0;
                end else if (t <= 1) begin
                    ef = 5'b01001; er = '0; ec = '0;
                end else if (t <= kk[d] + 1) begin
                    ef = 5'b01000; er = '0; ec = CW'(t - 2);
                end else if (t == kk[d] + 2) begin
                    ef = {3'b001, tt[d], 1'b1}; er = rr[d]; ec = CW'(kk[d]);
                end else begin
                    ef = 5'b10001; er = rr[d]; ec = CW'(kk[d]);
                end
                checks++;
                if (o_flg[d] !== ef) begin
                    errors++;
                    $display("FAIL %s flags dut%0d t=%0d got %b want %b (ready,busy,done,timed_out,cpu_reset)", name, d, t, o_flg[d], ef);
                end
                checks++;
                if (o_res[d] !== er) begin
                    errors++;
                    $display("FAIL %s result dut%0d t=%0d got %0d want %0d", name, d, t, o_res[d], er);
                end
                checks++;
                if (o_cyc[d] !== ec) begin
                    errors++;
                    $display("FAIL %s cycles dut%0d t=%0d got %0d want %0d", name, d, t, o_cyc[d], ec);
                end
                checks++;
                if (o_cin[d] !== a) begin
                    errors++;
                    $display("FAIL %s cpu_input dut%0d t=%0d got %0d want %0d", name, d, t, o_cin[d], a);
                end
            end
            start = 1'b0; abort = 1'b0;
            cpu_out = (t >= 2 && t - 1 <= TMO) ? seq[t - 1] : DW'($urandom);
            if (t == abort_t) abort = 1'b1;
            // Starts while busy or finishing must be ignored.
            if (noise && t <= kmin + 1 && (abort_t < 0 || t < abort_t)) begin
                start = 1'($urandom_range(0, 1));
                arg   = DW'($urandom);
            end
        end
        start = 1'b0; abort = 1'b0; cpu_out = '0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_flg[d] !== 5'b10001 || o_res[d] !== '0 || o_cyc[d] !== '0 || o_cin[d] !== '0) begin
                errors++;
                $display("FAIL reset_values dut%0d got flags=%b result=%0d cycles=%0d cpu_input=%0d want flags=10001 rest 0",
                         d, o_flg[d], o_res[d], o_cyc[d], o_cin[d]);
            end
        end
    endtask

    task automatic test_basic();
        for (int k = 1; k <= TMO; k++) seq[k] = (k >= 41) ? DW'(11) : '0;
        do_run("basic_5040", 16'h13B0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= TMO; k++) seq[k] = (k >= 20) ? DW'(17) : '0;
        do_run("b2b_30030", DW'(30030), -1, 1'b1);
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= TMO; k++) seq[k] = '0;
        do_run("timeout", 16'h0007, -1, 1'b1);
    endtask

    task automatic test_tie();
        for (int k = 1; k <= TMO; k++) seq[k] = (k == TMO) ? DW'(7) : '0;
        do_run("complete_at_timeout", 16'h00A5, -1, 1'b0);
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= TMO; k++) seq[k] = (k >= 6) ? DW'(9) : '0;
        seq[4] = DW'(5);
        do_run("glitch", 16'h0033, -1, 1'b0);
    endtask

    task automatic test_abort();
        for (int k = 1; k <= TMO; k++) seq[k] = '0;
        do_run("abort_run10", 16'h1234, 11, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1; arg = 16'hBEEF;
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_flg[d] !== 5'b10001 || o_cin[d] !== last_arg) begin
                errors++;
                $display("FAIL start_with_abort dut%0d got flags=%b cpu_input=%0d want flags=10001 cpu_input=%0d",
                         d, o_flg[d], o_cin[d], last_arg);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= TMO; k++) seq[k] = '0;
        start = 1'b1; arg = 16'h0BAD;
        for (int t = 0; t <= 12; t++) begin
            @(posedge CLK); #1; start = 1'b0;
        end
        checks++;
        if (o_flg[0] !== 5'b01000) begin
            errors++;
            $display("FAIL async_reset_prerun got flags %b want 01000", o_flg[0]);
        end
        #2 reset = 1'b1;
        #1;
        test_reset();
        @(posedge CLK); #3 reset = 1'b0;
        @(posedge CLK); #1;
        for (int c = 0; c < 4; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_flg[d] !== 5'b10001 || o_cin[d] !== '0) begin
                    errors++;
                    $display("FAIL after_reset_idle dut%0d c=%0d got flags=%b cpu_input=%0d want 10001 and 0", d, c, o_flg[d], o_cin[d]);
                end
            end
            @(posedge CLK); #1;
        end
        for (int k = 1; k <= TMO; k++) seq[k] = (k >= 4) ? DW'(42) : '0;
        do_run("after_reset", 16'h0042, -1, 1'b0);
    endtask

    task automatic test_random();
        int            k1, k3, len, abort_t;
        logic [DW-1:0] v, rdummy;
        bit            tdummy;
        for (int it = 0; it < 8; it++) begin
            len = 0; v = '0;
            for (int k = 1; k <= TMO; k++) begin
                if (len == 0) begin
                    case ($urandom_range(0, 3))
                        0: v = '0;
                        1: v = DW'(5);
                        default: v = DW'(9);
                    endcase
                    len = $urandom_range(1, 4);
                end
                seq[k] = v; len--;
            end
            ref_run(1, k1, rdummy, tdummy);
            ref_run(3, k3, rdummy, tdummy);
            abort_t = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ((k1 < k3) ? k1 : k3) + 1) : -1;
            do_run("random", DW'($urandom), abort_t, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; arg = '0; cpu_out = '0; last_arg = '0;
        #2;
        test_reset();
        #10 reset = 1'b0;
        @(posedge CLK); #1;
        test_basic();
        test_back_to_back();
        test_timeout();
        test_tie();
        test_glitch();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
